scoreboarded_regfile: RTL and testbench
=======================================

# scoreboarded_regfile

Parametrised integer register file for the synchronous core, replacing the flat register array and its unchecked write-back. Provides NRD combinational read ports and one write-back port with write-to-read bypass. A per-register pending-write scoreboard tracks registers whose producers have issued but not yet written back. The block raises a stall when an issuing instruction reads, or would overwrite, a pending register.

## Interface
Parameters:
- XLEN, 32, register data width
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports
- AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd_use  in  NRD  port k operand is actually consumed by the issuing instruction
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  addressed register pending after same-cycle write-back clear
- iss_valid  in  1  instruction issuing that will write iss_rd
- iss_rd  in  AW  destination of issuing instruction
- stall  out  1  issue must be held this cycle
- wb_valid  in  1  write-back valid
- wb_addr  in  AW  write-back destination
- wb_data  in  XLEN  write-back data
- pend_cnt  out  AW+1  number of registers currently pending

## Operation
- Register 0 reads 0 and is never written or pending. Writes and issues to address 0 are discarded.
- Read, port k:
  - If wb_valid and wb_addr==rd_addr[k]≠0, return wb_data (bypass).
  - Otherwise return the array value.
- rd_busy[k] = sb[rd_addr[k]] & ~(wb_valid & wb_addr==rd_addr[k]).
- stall = |(rd_busy & rd_use) | (iss_valid & sb_eff[iss_rd]), where sb_eff is sb after the same-cycle wb clear. A pending destination is a WAW stall.
- The scoreboard updates on every rising edge, in this order:
  1. Clear sb[wb_addr] if wb_valid.
  2. Then set sb[iss_rd] if iss_valid & ~stall & iss_rd≠0.
  3. If both target the same register, the set wins; the bit stays 1.
- Array write: on rising edge, reg[wb_addr] ← wb_data if wb_valid & wb_addr≠0. A write-back to a non-pending register is legal and updates the array.
- pend_cnt is a registered counter: +1 on an accepted set of a clear bit, −1 on a clear of a set bit, net 0 when both happen. It must always equal popcount(sb).

## Timing
- Reset (async assert):
  - all registers are 0
  - sb is all 0
  - pend_cnt = 0
  - rd_busy = 0 and stall = 0 unless iss_valid targets… none are pending, so stall = 0
- Reset deassertion: the first edge after deassertion performs a normal update.
- Read latency is 0 cycles (combinational).
- Write-back is visible:
  - the same cycle on rd_data via bypass
  - from the array the cycle after the edge
- Issue→busy: a register accepted at edge N shows rd_busy=1 from cycle N+1 until its write-back cycle. It shows rd_busy=0 in the write-back cycle itself.
- Back-to-back: issue and write-back of the same register in one cycle keeps it pending with the new data written.
- Reset mid-operation discards all pending state. Outstanding write-backs arriving after reset still write the array.

## Structure
- Shared package core_pkg holds:
  - XLEN_DEF = 32
  - NREGS_DEF = 32
  - ZERO_REG = 0
  - an rf_addr_t typedef of width AW
- One sub-module, regfile_scoreboard, contains the sb vector, pend_cnt counter and the stall/busy logic.
- The top level instantiates regfile_scoreboard beside the data array and bypass muxes.

## Test plan
- Reset with wb_valid=1, wb_addr=5, wb_data=0xDEAD held → all outputs 0. After deassert and one edge, reading x5 returns 0xDEAD.
- Same-cycle bypass: wb x7=0x1234, rd_addr[0]=7 → rd_data[0]=0x1234 in that cycle. The following cycle with wb_valid=0 still returns 0x1234.
- x0 immunity: wb x0=0xFFFF_FFFF with iss_rd=0 → x0 reads 0, pend_cnt stays 0, no stall.
- RAW stall: issue x3 at edge N. In cycle N+1, rd_addr[1]=3 with rd_use[1]=1 gives stall=1 and rd_busy[1]=1. When wb x3=0x55 arrives: stall=0, rd_data[1]=0x55. pend_cnt goes 0→1→0.
- WAW and simultaneous events:
  - With x9 pending, iss_rd=9 → stall=1.
  - With wb x9 and iss x9 in the same cycle → stall=0, x9 remains pending, pend_cnt unchanged.
- Fill: issue x1..x31 on consecutive cycles → pend_cnt=31. Random write-backs then drain it to 0 with pend_cnt==popcount(sb) every cycle.

Source files
------------

// File: rtl/scoreboarded_regfile_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared constants and types for the integer register file and its
//   scoreboard.
//     XLEN_DEF   default register data width
//     NREGS_DEF  default number of architectural registers
//     ZERO_REG   hard-wired zero register index
//     rf_addr_t  register address type for the default register count
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned ZERO_REG  = 0;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] rf_addr_t;

endpackage

// File: rtl/scoreboarded_regfile_if.sv
// -----------------------------------------------------------------------------
// scoreboarded_regfile_if
//   Issue / read / write-back bundle of the scoreboarded register file.
//     rd_addr, rd_use      read port addresses and operand-consumed flags
//     rd_data, rd_busy     read data and per-port pending indication
//     iss_valid, iss_rd    issuing instruction and its destination
//     stall                issue must be held this cycle
//     wb_valid, wb_addr,
//     wb_data              write-back port
//     pend_cnt             number of pending registers
//   master: pipeline side, slave: register file side.
// -----------------------------------------------------------------------------
interface scoreboarded_regfile_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_use;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                stall;
    logic                wb_valid;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic [AW:0]         pend_cnt;

    modport master (
        output rd_addr, rd_use, iss_valid, iss_rd, wb_valid, wb_addr, wb_data,
        input  rd_data, rd_busy, stall, pend_cnt
    );

    modport slave (
        input  rd_addr, rd_use, iss_valid, iss_rd, wb_valid, wb_addr, wb_data,
        output rd_data, rd_busy, stall, pend_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Pending-write scoreboard for the register file.
//     clk, rst             clock, asynchronous active-high reset
//     rd_addr, rd_use      read port addresses and operand-consumed flags
//     iss_valid, iss_rd    issuing instruction and destination
//     wb_valid, wb_addr    write-back clearing a pending bit
//     rd_busy              per-port pending after same-cycle write-back clear
//     stall                RAW on a consumed operand or WAW on the destination
//     pend_cnt             registered popcount of the scoreboard
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    rd_use,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic              stall,
    output logic [AW:0]       pend_cnt
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_eff;
    logic [NREGS-1:0] sb_next;
    logic             set_ok;
    logic             clr_hit;

    // Scoreboard as seen after this cycle's write-back has retired.
    always_comb begin
        sb_eff = sb;
        if (wb_valid) begin
            sb_eff[wb_addr] = 1'b0;
        end
    end

    // sb[0] is never set, so indexing sb_eff equals the sb & ~wb-match form.
    always_comb begin
        rd_busy = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_busy[k] = sb_eff[rd_addr[k*AW +: AW]];
        end
    end

    assign stall   = (|(rd_busy & rd_use)) | (iss_valid & sb_eff[iss_rd]);
    assign set_ok  = iss_valid & ~stall & (iss_rd != ZERO_A);
    assign clr_hit = wb_valid & sb[wb_addr];

    // An accepted set always targets a bit that is clear in sb_eff, so the
    // counter's +1/-1 terms are exactly set_ok and clr_hit; a same-register
    // clear-and-set nets to zero while the bit stays 1.
    always_comb begin
        sb_next = sb_eff;
        if (set_ok) begin
            sb_next[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb       <= '0;
            pend_cnt <= '0;
        end else begin
            sb       <= sb_next;
            pend_cnt <= pend_cnt + {{AW{1'b0}}, set_ok} - {{AW{1'b0}}, clr_hit};
        end
    end

endmodule

// File: rtl/scoreboarded_regfile.sv
// -----------------------------------------------------------------------------
// scoreboarded_regfile
//   Integer register file with NRD combinational read ports, one write-back
//   port with write-to-read bypass, and a pending-write scoreboard that
//   raises stall on RAW/WAW hazards against in-flight producers.
//     clk   core clock, all state updates on the rising edge
//     rst   asynchronous active-high reset, clears array and scoreboard
//     bus   scoreboarded_regfile_if slave: read, issue, write-back, status
// -----------------------------------------------------------------------------
module scoreboarded_regfile
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    scoreboarded_regfile_if.slave  bus
);

    localparam int unsigned   AW     = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_busy_c;
    logic                stall_c;
    logic [AW:0]         pend_cnt_c;

    // Register 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_valid && (bus.wb_addr != ZERO_A)) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rd_data_c = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (bus.wb_valid
                && (bus.wb_addr == bus.rd_addr[k*AW +: AW])
                && (bus.rd_addr[k*AW +: AW] != ZERO_A)) begin
                rd_data_c[k*XLEN +: XLEN] = bus.wb_data;
            end else begin
                rd_data_c[k*XLEN +: XLEN] = regs[bus.rd_addr[k*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (bus.rd_addr),
        .rd_use    (bus.rd_use),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .wb_valid  (bus.wb_valid),
        .wb_addr   (bus.wb_addr),
        .rd_busy   (rd_busy_c),
        .stall     (stall_c),
        .pend_cnt  (pend_cnt_c)
    );

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.stall    = stall_c;
    assign bus.pend_cnt = pend_cnt_c;

endmodule

// File: tb/tb_scoreboarded_regfile.sv
// -----------------------------------------------------------------------------
// tb_scoreboarded_regfile
//   Directed self-checking bench for scoreboarded_regfile.
// -----------------------------------------------------------------------------
module tb_scoreboarded_regfile;
    import core_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    scoreboarded_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    scoreboarded_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int unsigned k, input rf_addr_t a);
        bus.rd_addr[k*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rdd(input int unsigned k);
        return bus.rd_data[k*XLEN +: XLEN];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a write-back held on x5
        rst           = 1'b1;
        bus.rd_addr   = '0;
        bus.rd_use    = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd5;
        bus.wb_data   = 32'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd0",   rdd(0), 32'h0);
        chk("rst_rd1",   rdd(1), 32'h0);
        chk("rst_busy",  32'(bus.rd_busy), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_pend",  32'(bus.pend_cnt), 32'h0);
        rst = 1'b0;
        tick();
        bus.wb_valid = 1'b0;
        set_rd(0, 5'd5);
        #1;
        chk("post_rst_x5", rdd(0), 32'hDEAD);

        // Same-cycle bypass, then array read
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd7;
        bus.wb_data  = 32'h1234;
        set_rd(0, 5'd7);
        #1;
        chk("bypass_x7", rdd(0), 32'h1234);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk("array_x7", rdd(0), 32'h1234);

        // x0 immunity
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'hFFFF_FFFF;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        set_rd(0, 5'd0);
        #1;
        chk("x0_bypass", rdd(0), 32'h0);
        chk("x0_stall",  32'(bus.stall), 32'h0);
        tick();
        bus.wb_valid  = 1'b0;
        bus.iss_valid = 1'b0;
        #1;
        chk("x0_array", rdd(0), 32'h0);
        chk("x0_pend",  32'(bus.pend_cnt), 32'h0);

        // RAW stall on x3; a stalled issue of x4 must not be accepted
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd3;
        #1;
        chk("raw_iss_stall", 32'(bus.stall), 32'h0);
        tick();
        bus.iss_valid = 1'b0;
        set_rd(1, 5'd3);
        bus.rd_use = 2'b00;
        #1;
        chk("raw_unused_stall", 32'(bus.stall), 32'h0);
        chk("raw_unused_busy",  32'(bus.rd_busy[1]), 32'h1);
        bus.rd_use    = 2'b10;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd4;
        #1;
        chk("raw_stall", 32'(bus.stall), 32'h1);
        chk("raw_busy",  32'(bus.rd_busy[1]), 32'h1);
        chk("raw_pend1", 32'(bus.pend_cnt), 32'h1);
        tick();
        bus.iss_valid = 1'b0;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd3;
        bus.wb_data   = 32'h55;
        #1;
        chk("raw_wb_stall", 32'(bus.stall), 32'h0);
        chk("raw_wb_busy",  32'(bus.rd_busy[1]), 32'h0);
        chk("raw_wb_data",  rdd(1), 32'h55);
        chk("raw_x4_rej",   32'(bus.pend_cnt), 32'h1);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk("raw_pend0",  32'(bus.pend_cnt), 32'h0);
        chk("raw_arr_x3", rdd(1), 32'h55);
        bus.rd_use = 2'b00;

        // WAW and simultaneous issue/write-back on x9
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        tick();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        #1;
        chk("waw_pend1", 32'(bus.pend_cnt), 32'h1);
        chk("waw_stall", 32'(bus.stall), 32'h1);
        tick();
        chk("waw_pend_hold", 32'(bus.pend_cnt), 32'h1);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd9;
        bus.wb_data  = 32'hAB;
        #1;
        chk("sim_stall", 32'(bus.stall), 32'h0);
        tick();
        bus.wb_valid  = 1'b0;
        bus.iss_valid = 1'b0;
        set_rd(0, 5'd9);
        #1;
        chk("sim_pend", 32'(bus.pend_cnt), 32'h1);
        chk("sim_busy", 32'(bus.rd_busy[0]), 32'h1);
        chk("sim_data", rdd(0), 32'hAB);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd9;
        bus.wb_data  = 32'h0;
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk("sim_drain", 32'(bus.pend_cnt), 32'h0);

        // Fill x1..x31
        for (int unsigned r = 1; r < 32; r++) begin
            bus.iss_valid = 1'b1;
            bus.iss_rd    = rf_addr_t'(r);
            #1;
            chk($sformatf("fill_stall_x%0d", r), 32'(bus.stall), 32'h0);
            tick();
        end
        bus.iss_valid = 1'b0;
        #1;
        chk("fill_pend", 32'(bus.pend_cnt), 32'd31);

        // Drain in a scrambled order (stride 7 mod 31 covers x1..x31)
        for (int unsigned i = 0; i < 31; i++) begin
            rf_addr_t a;
            rf_addr_t b;
            a = rf_addr_t'(((i * 7) % 31) + 1);
            b = rf_addr_t'((((i + 1) * 7) % 31) + 1);
            bus.wb_valid = 1'b1;
            bus.wb_addr  = a;
            bus.wb_data  = 32'(a) * 32'h101;
            set_rd(0, a);
            set_rd(1, b);
            #1;
            chk($sformatf("drain_pend_%0d", i), 32'(bus.pend_cnt), 32'(31 - i));
            chk($sformatf("drain_busy_%0d", i), 32'(bus.rd_busy[0]), 32'h0);
            chk($sformatf("drain_data_%0d", i), rdd(0), 32'(a) * 32'h101);
            chk($sformatf("drain_stall_%0d", i), 32'(bus.stall), 32'h0);
            if (i < 30) begin
                chk($sformatf("drain_next_busy_%0d", i), 32'(bus.rd_busy[1]), 32'h1);
            end
            tick();
        end
        bus.wb_valid = 1'b0;
        #1;
        chk("drain_pend_end", 32'(bus.pend_cnt), 32'h0);

        // Reset mid-operation, then a late write-back still lands
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd12;
        tick();
        bus.iss_valid = 1'b0;
        set_rd(0, 5'd7);
        set_rd(1, 5'd12);
        #1;
        chk("mid_pend1", 32'(bus.pend_cnt), 32'h1);
        chk("mid_x7",    rdd(0), 32'h707);
        rst = 1'b1;
        #1;
        chk("mid_rst_pend", 32'(bus.pend_cnt), 32'h0);
        chk("mid_rst_x7",   rdd(0), 32'h0);
        chk("mid_rst_busy", 32'(bus.rd_busy[1]), 32'h0);
        rst = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd12;
        bus.wb_data  = 32'h77;
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk("late_wb_x12",   rdd(1), 32'h77);
        chk("late_wb_pend",  32'(bus.pend_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
